// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that merges N_REQ beat streams into a single FIFO
// write port. A grant is held for a whole packet: it ends on the owner's
// req_last beat, or it is force-released after MAX_BURST beats. Every
// grant is followed by one IDLE cycle in which the next owner is selected.
//
// Ports
//   clk          FIFO write-side clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester beat valid
//   req_last     per-requester final-beat marker (qualified by req_valid)
//   req_data     per-requester beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester beat accepted (only the owner can be ready)
//   w_valid      beat valid toward the FIFO
//   w_data       beat data toward the FIFO
//   w_ready      FIFO not full
//   grant_valid  a requester owns the write port
//   grant_id     index of the owning requester
//   burst_cnt    beats accepted in the current grant
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; pick next requester round-robin from rr_ptr
// S_BURST | grant_id owns the write port until last beat or MAX_BURST

module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          w_valid,
    output logic [DATA_WIDTH-1:0]         w_data,
    input  logic                          w_ready,
    output logic                          grant_valid,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic [$clog2(MAX_BURST):0]    burst_cnt
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
    localparam logic [GW-1:0] TOP_ID   = GW'(N_REQ - 1);

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic [GW-1:0] pick_id;
    logic          pick_found;
    logic [GW-1:0] next_ptr;
    logic          in_burst;
    logic          owner_valid;
    logic          owner_last;
    logic          beat;
    logic          grant_end;

    // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
    // Only req_valid takes part; last/data are irrelevant until granted.
    always_comb begin : rr_search
        int idx;
        idx        = 0;
        pick_id    = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = GW'(idx);
            end
        end
    end

    assign next_ptr    = (grant_id_q == TOP_ID) ? '0 : grant_id_q + 1'b1;
    assign in_burst    = (state_q == S_BURST);
    assign owner_valid = req_valid[grant_id_q];
    assign owner_last  = req_last[grant_id_q];
    assign beat        = in_burst && owner_valid && w_ready;
    assign grant_end   = owner_last || (burst_cnt_q == LAST_CNT);

    // Write-port mux: everything is forced low outside a burst so that a
    // non-owner can never see ready and the FIFO never sees a stray beat.
    always_comb begin : port_mux
        w_valid   = 1'b0;
        w_data    = '0;
        req_ready = '0;
        if (in_burst) begin
            w_valid               = owner_valid;
            w_data                = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
            req_ready[grant_id_q] = w_ready;
        end
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_id;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                // Owner dropping valid or FIFO full simply holds everything.
                if (beat) begin
                    if (grant_end) begin
                        state_d     = S_IDLE;
                        rr_ptr_d    = next_ptr;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_valid = in_burst;
    assign grant_id    = grant_id_q;
    assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 16;
    localparam int DW        = 8;
    localparam int GW        = 2;
    localparam int CW        = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ-1:0]      req_last = '0;
    logic [N_REQ*DW-1:0]   req_data = '0;
    logic [N_REQ-1:0]      req_ready;
    logic                  w_valid;
    logic [DW-1:0]         w_data;
    logic                  w_ready = 1'b1;
    logic                  grant_valid;
    logic [GW-1:0]         grant_id;
    logic [CW-1:0]         burst_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ(N_REQ), .MAX_BURST(MAX_BURST), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .grant_valid(grant_valid), .grant_id(grant_id), .burst_cnt(burst_cnt)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       wr;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] ready;
        logic       wv;
        int         cnt;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic wr,
                                input logic gv, input logic [1:0] gid, input logic [3:0] rdy,
                                input logic wv, input int cnt);
        vec_t t;
        t.valid = v; t.last = l; t.wr = wr; t.gv = gv; t.gid = gid;
        t.ready = rdy; t.wv = wv; t.cnt = cnt;
        return t;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < N_REQ; i++) begin
            if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; req_last = '0; w_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_fixed_data();
        for (int r = 0; r < N_REQ; r++) req_data[r*DW +: DW] = 8'(8'h11 * (r + 1));
    endtask

    // Random-phase state
    logic [DW-1:0] sbq[N_REQ][$];
    logic [5:0]    seq[N_REQ];
    logic [3:0]    pend, acc;
    logic          waiting[N_REQ];
    int            waitg[N_REQ];

    initial begin
        int beats, gbeats, first_len, n_end, mrr, mcnt, exp_gid, g;
        logic prev_gv, exp_gv;
        logic [DW-1:0] exp_d;

        // ---------------- reset state ----------------
        set_fixed_data();
        req_valid = 4'hF;
        #12;
        chk("rst_gv", grant_valid, 0);
        chk("rst_wv", w_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_wdata", w_data, 0);
        req_valid = '0;
        apply_reset();

        // ---------------- table-driven vectors ----------------
        tbl[0]  = mk(4'hF, 4'hF, 1, 0, 0, 4'h0, 0, 0);
        tbl[1]  = mk(4'hF, 4'hF, 1, 1, 0, 4'h1, 1, 0);
        tbl[2]  = mk(4'hF, 4'hF, 1, 0, 0, 4'h0, 0, 0);
        tbl[3]  = mk(4'hF, 4'hF, 1, 1, 1, 4'h2, 1, 0);
        tbl[4]  = mk(4'hF, 4'hF, 1, 0, 0, 4'h0, 0, 0);
        tbl[5]  = mk(4'hF, 4'hF, 1, 1, 2, 4'h4, 1, 0);
        tbl[6]  = mk(4'hF, 4'hF, 1, 0, 0, 4'h0, 0, 0);
        tbl[7]  = mk(4'hF, 4'hF, 1, 1, 3, 4'h8, 1, 0);
        tbl[8]  = mk(4'hF, 4'hF, 1, 0, 0, 4'h0, 0, 0);
        tbl[9]  = mk(4'hF, 4'hF, 1, 1, 0, 4'h1, 1, 0);
        tbl[10] = mk(4'h4, 4'h0, 1, 0, 0, 4'h0, 0, 0);
        tbl[11] = mk(4'h5, 4'h0, 1, 1, 2, 4'h4, 1, 0);
        tbl[12] = mk(4'h5, 4'h0, 0, 1, 2, 4'h0, 1, 1);
        tbl[13] = mk(4'h5, 4'h0, 0, 1, 2, 4'h0, 1, 1);
        tbl[14] = mk(4'h1, 4'h0, 1, 1, 2, 4'h4, 0, 1);
        tbl[15] = mk(4'h5, 4'h4, 1, 1, 2, 4'h4, 1, 1);
        tbl[16] = mk(4'h9, 4'h0, 1, 0, 0, 4'h0, 0, 0);
        tbl[17] = mk(4'h9, 4'h8, 1, 1, 3, 4'h8, 1, 0);
        tbl[18] = mk(4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 0);
        tbl[19] = mk(4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            req_valid = tbl[i].valid; req_last = tbl[i].last; w_ready = tbl[i].wr;
            @(negedge clk);
            chk($sformatf("vec%0d_gv", i), grant_valid, tbl[i].gv);
            if (tbl[i].gv) chk($sformatf("vec%0d_gid", i), grant_id, tbl[i].gid);
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].ready);
            chk($sformatf("vec%0d_wv", i), w_valid, tbl[i].wv);
            chk($sformatf("vec%0d_cnt", i), burst_cnt, tbl[i].cnt);
            exp_d = tbl[i].gv ? 8'(8'h11 * (tbl[i].gid + 1)) : 8'h00;
            chk($sformatf("vec%0d_wdata", i), w_data, exp_d);
        end

        // ---------------- packet lock ----------------
        // One single-beat grant to requester 1 moves rr_ptr to 2.
        @(posedge clk); #1;
        req_valid = 4'b0010; req_last = 4'b0010;
        @(negedge clk); @(negedge clk);
        chk("lock_pre_gid", grant_id, 1);
        @(posedge clk); #1;
        req_valid = 4'b0101; req_last = 4'b0000;
        beats = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (grant_valid && w_valid && w_ready) begin
                chk("lock_owner", grant_id, 2);
                chk("lock_ready0", req_ready[0], 0);
                beats++;
            end
            if (beats == 5) break;
            @(posedge clk); #1;
            req_last[2] = (beats == 4);
        end
        chk("lock_beats", beats, 5);
        @(posedge clk); #1;
        req_valid = 4'b0001; req_last = 4'b0001;
        @(negedge clk);
        chk("lock_gap_gv", grant_valid, 0);
        @(negedge clk);
        chk("lock_next_gv", grant_valid, 1);
        chk("lock_next_gid", grant_id, 0);

        // ---------------- forced release ----------------
        apply_reset();
        @(posedge clk); #1;
        req_valid = 4'b0010; req_last = 4'b0000; w_ready = 1'b1;
        beats = 0; gbeats = 0; first_len = -1; n_end = 0; prev_gv = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (!grant_valid && prev_gv) begin
                if (n_end == 0) first_len = gbeats;
                n_end++;
                gbeats = 0;
                chk("fr_cnt_clear", burst_cnt, 0);
            end
            if (grant_valid && w_valid && w_ready) begin
                chk("fr_cnt", burst_cnt, gbeats);
                beats++; gbeats++;
            end
            prev_gv = grant_valid;
            if (beats == 20) break;
            @(posedge clk); #1;
        end
        chk("fr_total", beats, 20);
        chk("fr_first_len", first_len, 16);
        chk("fr_ends", n_end, 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("fr_hold_gv", grant_valid, 1);
        chk("fr_hold_cnt", burst_cnt, 4);
        chk("fr_hold_wv", w_valid, 0);

        // ---------------- reset mid-burst ----------------
        apply_reset();
        @(posedge clk); #1;
        req_valid = 4'b0010; req_last = 4'b0000;
        beats = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant_valid && burst_cnt == 2) begin
                beats = 1;
                break;
            end
        end
        chk("rm_reached_beat3", beats, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_gv", grant_valid, 0);
        chk("rm_wv", w_valid, 0);
        chk("rm_ready", req_ready, 0);
        chk("rm_wdata", w_data, 0);
        chk("rm_cnt", burst_cnt, 0);
        @(negedge clk);
        chk("rm_held_wv", w_valid, 0);
        rst_n = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("rm_after_gv", grant_valid, 1);
        chk("rm_after_gid", grant_id, 0);
        chk("rm_after_wdata", w_data, 8'h11);

        // ---------------- random traffic with scoreboard ----------------
        apply_reset();
        pend = '0; acc = '0;
        for (int r = 0; r < N_REQ; r++) begin
            seq[r] = '0; waiting[r] = 1'b0; waitg[r] = 0;
        end
        mrr = 0; mcnt = 0; exp_gv = 1'b0; exp_gid = 0; prev_gv = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < N_REQ; r++) begin
                if (acc[r]) begin
                    pend[r] = 1'b0; acc[r] = 1'b0;
                end
                if (!pend[r] && $urandom_range(1, 0) == 1) begin
                    pend[r] = 1'b1;
                    req_data[r*DW +: DW] = {2'(r), seq[r]};
                    seq[r] = seq[r] + 6'd1;
                    req_last[r] = ($urandom_range(7, 0) == 0);
                    sbq[r].push_back(req_data[r*DW +: DW]);
                end
            end
            req_valid = pend;
            w_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            chk("rnd_gv", grant_valid, exp_gv);
            if (grant_valid && !prev_gv) begin
                chk("rnd_gid", grant_id, exp_gid);
                for (int r = 0; r < N_REQ; r++) begin
                    if (waiting[r]) begin
                        if (r == int'(grant_id)) begin
                            waiting[r] = 1'b0;
                        end else begin
                            waitg[r]++;
                            chk("rnd_fair", (waitg[r] <= N_REQ - 1), 1);
                        end
                    end
                end
            end
            if (grant_valid) begin
                g = int'(grant_id);
                chk("rnd_ready", req_ready, w_ready ? (4'b0001 << g) : 4'b0000);
                chk("rnd_wv", w_valid, req_valid[g]);
                chk("rnd_cnt", burst_cnt, mcnt);
                if (w_valid && w_ready) begin
                    chk("rnd_sbq_nonempty", (sbq[g].size() != 0), 1);
                    if (sbq[g].size() != 0) begin
                        exp_d = sbq[g].pop_front();
                        chk("rnd_data", w_data, exp_d);
                    end
                    acc[g] = 1'b1;
                    if (req_last[g] || mcnt == MAX_BURST - 1) begin
                        mcnt = 0; mrr = (g + 1) % N_REQ; exp_gv = 1'b0;
                    end else begin
                        mcnt++; exp_gv = 1'b1;
                    end
                end else begin
                    exp_gv = 1'b1;
                end
            end else begin
                chk("rnd_idle_ready", req_ready, 0);
                chk("rnd_idle_wv", w_valid, 0);
                chk("rnd_idle_cnt", burst_cnt, 0);
                exp_gv = |req_valid;
                exp_gid = pick(req_valid, mrr);
                for (int r = 0; r < N_REQ; r++) begin
                    if (req_valid[r] && !waiting[r]) begin
                        waiting[r] = 1'b1; waitg[r] = 0;
                    end
                end
            end
            prev_gv = grant_valid;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters (2..16); MAX_BURST, default 16, maximum beats per grant (1..256); DATA_WIDTH, from async_fifo_package, beat width.
REQ-002 clk  input  1  single block clock, the FIFO write-side clock.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 req_valid  input  N_REQ  per-requester beat valid.
REQ-005 req_last  input  N_REQ  per-requester final-beat marker, qualified by req_valid.
REQ-006 req_data  input  N_REQ*DATA_WIDTH  per-requester beat data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 req_ready  output  N_REQ  per-requester beat accepted when paired with req_valid.
REQ-008 w_valid  output  1  beat valid toward the FIFO write port.
REQ-009 w_data  output  DATA_WIDTH  beat data toward the FIFO write port.
REQ-010 w_ready  input  1  FIFO not full.
REQ-011 grant_valid  output  1  a requester currently owns the write port.
REQ-012 grant_id  output  clog2(N_REQ)  index of the owning requester.
REQ-013 burst_cnt  output  clog2(MAX_BURST)+1  beats accepted in the current grant.

Function
REQ-014 The block SHALL implement two states, IDLE and BURST; grant_valid SHALL be 1 exactly in BURST.
REQ-015 In IDLE, w_valid, w_data and all req_ready bits SHALL be 0.
REQ-016 In IDLE, if any req_valid bit is 1, the block SHALL select the first requester with req_valid=1, searching upward from rr_ptr modulo N_REQ; it SHALL register grant_id and enter BURST on the next edge (one-cycle arbitration latency).
REQ-017 req_last and req_data SHALL be ignored during arbitration; arbitration SHALL use req_valid only.
REQ-018 In BURST, w_valid SHALL equal req_valid[grant_id] and w_data SHALL equal the grant_id data slice, both combinationally.
REQ-019 In BURST, req_ready[grant_id] SHALL equal w_ready combinationally; all other req_ready bits SHALL be 0.
REQ-020 A beat SHALL be defined as w_valid=1 and w_ready=1 on a rising clk edge; burst_cnt SHALL increment by 1 per beat.
REQ-021 A grant SHALL end on a beat where req_last[grant_id]=1, or on a beat where burst_cnt=MAX_BURST-1 (forced release), whichever comes first.
REQ-022 At grant end, the block SHALL set rr_ptr to (grant_id+1) mod N_REQ, clear burst_cnt to 0 and return to IDLE on that same edge.
REQ-023 The block SHALL NOT transfer a beat in the IDLE cycle that follows a grant end, so each grant costs one idle cycle.
REQ-024 If req_valid[grant_id] drops mid-burst, the block SHALL keep the grant and hold burst_cnt; there is no idle timeout.
REQ-025 If w_ready=0 (FIFO full), the block SHALL stall the owner with req_ready=0, and burst_cnt and the grant SHALL be held.
REQ-026 Requests from non-owners SHALL be ignored, and their req_ready SHALL stay 0 until a later arbitration selects them.
REQ-027 When only one requester is active, it SHALL be re-granted after each one-cycle IDLE gap.
REQ-028 Fairness: a continuously requesting requester SHALL be granted within N_REQ-1 grants after its request is first seen in IDLE.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force state IDLE, rr_ptr=0, grant_id=0, grant_valid=0 and burst_cnt=0, which makes w_valid=0, w_data=0 and req_ready=0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst without a further beat; the partial packet already written remains in the FIFO.
REQ-031 After rst_n is released, the first arbitration SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-032 Arbitration order: after reset, all 4 requesters assert valid with req_last on every beat and w_ready=1 -> grants occur in order 0,1,2,3,0, one beat each, with one IDLE cycle between grants.
REQ-033 Packet lock: requester 2 sends 5 beats, last on beat 5, while requester 0 also requests -> 5 consecutive beats from requester 2, then a grant to requester 3 if it is requesting, otherwise to requester 0.
REQ-034 Forced release: MAX_BURST=16 and requester 1 streams 20 beats with no req_last -> grant ends after beat 16, burst_cnt returns to 0, and the remaining 4 beats go in a later grant.
REQ-035 Backpressure: w_ready=0 for 3 cycles mid-burst -> req_ready[grant_id]=0, burst_cnt held, no beat lost or duplicated, and the burst resumes when w_ready=1.
REQ-036 Reset mid-operation: rst_n=0 during beat 3 of a burst -> outputs go to 0 asynchronously; after release, requesters 0 and 3 are both valid -> requester 0 is granted first.
REQ-037 Data integrity: random valid, last and w_ready on 4 requesters over 10k cycles -> a scoreboard shows the per-requester beat order preserved, no packet interleaving except at forced releases, and the REQ-028 bound met.
